// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioning block.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic N-flop synchroniser for a single asynchronous input bit.
module bit_sync
  import button_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift chain, oldest sample at the top bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_pulse.sv
// Push-button conditioner: synchroniser, debounce FSM, one-cycle press pulse and debounced level.
// Define BUTTON_REPEAT_EN to add auto-repeat pulses while the button stays held.
module button_pulse
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_in,
  output logic impulse,
  output logic btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 32'sd1);

  logic          btn_sync_s;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_fire_s;
  logic          rep_fire_s;
  logic          impulse_q;
  logic          level_q;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(nrst),
    .d_i   (btn_in),
    .q_o   (btn_sync_s)
  );

  // FSM state and debounce counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state; the counter restarts on every state change so it can never wrap
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_fire_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d      = PRESSED;
          cnt_d        = CNT_ZERO;
          press_fire_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync_s) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

`ifdef BUTTON_REPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 32'sd1);
  localparam logic [RW-1:0] REP_ZERO   = {RW{1'b0}};
  localparam logic [RW-1:0] REP_ONE    = RW'(1'b1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 32'sd1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rep_q, rep_d;

  // repeat counter register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rep_q <= REP_ZERO;
    end else begin
      rep_q <= rep_d;
    end
  end

  // reaching REPEAT_DELAY fires and reloads, so later pulses come every REPEAT_PERIOD
  always_comb begin
    rep_d      = REP_ZERO;
    rep_fire_s = 1'b0;
    if ((state_q == PRESSED) && (state_d == PRESSED)) begin
      if (rep_q == REP_LAST) begin
        rep_d      = REP_RELOAD;
        rep_fire_s = 1'b1;
      end else begin
        rep_d = rep_q + REP_ONE;
      end
    end else begin
      rep_d = REP_ZERO;
    end
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  // registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      impulse_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      impulse_q <= press_fire_s | rep_fire_s;
      level_q   <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
  end

  assign impulse   = impulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_pulse.sv
// Scoreboard bench for button_pulse: run-length reference model predicts pulses and level.
module tb_button_pulse;

  localparam int D  = 4;
  localparam int S  = 2;
  localparam int RD = 20;
  localparam int RP = 6;

  logic clk    = 1'b0;
  logic nrst   = 1'b0;
  logic btn_in = 1'b0;
  logic impulse;
  logic btn_level;

  button_pulse #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn_in   (btn_in),
    .impulse  (impulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  int total       = 0;
  int bad         = 0;
  int cyc         = 0;
  int pulses_seen = 0;
  int exp_q[$];
  bit hist[$];
  bit m_level;
  int m_run;
  int m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
    m_level = 1'b0;
    m_run   = 0;
    m_hold  = 0;
  endfunction

  // Reference: s is btn_in delayed by S samples; the level flips once D+1 consecutive
  // samples disagree with it, and every flip to 1 is a press pulse.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        model_clear();
      end else begin
        bit s;
        bit was_p;
        bit now_p;
        cyc++;
        s = hist.pop_front();
        hist.push_back(btn_in);
        was_p = m_level && (m_run == 0);
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
          m_level = !m_level;
          m_run   = 0;
          if (m_level) exp_q.push_back(cyc);
        end
        now_p = m_level && (m_run == 0);
`ifdef BUTTON_REPEAT_EN
        if (was_p && now_p) begin
          m_hold++;
          if (m_hold >= RD && ((m_hold - RD) % RP) == 0) exp_q.push_back(cyc);
        end else begin
          m_hold = 0;
        end
`else
        if (was_p && now_p) m_hold++;
        else m_hold = 0;
`endif
      end
    end
  end

  // monitor: compares level every cycle and matches each impulse against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (nrst) begin
        check("btn_level", {31'd0, btn_level}, {31'd0, m_level});
        if (impulse === 1'b1) begin
          pulses_seen++;
          if (exp_q.size() == 0) check("impulse_unexpected", {31'd0, impulse}, 32'd0);
          else check("impulse_cycle", cyc, exp_q.pop_front());
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
          check("impulse_missing", {31'd0, impulse}, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    #1 nrst = 1'b1;
  endtask

  int  base;
  bit  got;
  int  n_expect_rep;

  initial begin
    #1;
    check("reset_impulse", {31'd0, impulse}, 32'd0);
    check("reset_level", {31'd0, btn_level}, 32'd0);
    release_reset();
    hold(1'b0, 5);

    // clean press
    base = pulses_seen;
    hold(1'b1, 30);
    hold(1'b0, 15);
    check("clean_press_count", pulses_seen - base, 32'd1);

    // glitch rejection
    base = pulses_seen;
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("glitch_count", pulses_seen - base, 32'd0);

    // press bounce
    base = pulses_seen;
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 20);
    hold(1'b0, 15);
    check("press_bounce_count", pulses_seen - base, 32'd1);

    // release bounce
    base = pulses_seen;
    hold(1'b1, 15);
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 15);
    check("release_bounce_count", pulses_seen - base, 32'd1);

    // reset during PRESS_WAIT, button held through release
    hold(1'b1, 4);
    #2 nrst = 1'b0;
    #1;
    check("rst_pw_impulse", {31'd0, impulse}, 32'd0);
    check("rst_pw_level", {31'd0, btn_level}, 32'd0);
    release_reset();
    base = pulses_seen;
    hold(1'b1, 20);
    hold(1'b0, 15);
    check("rst_pw_after_count", pulses_seen - base, 32'd1);

    // reset during the impulse cycle
    btn_in = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #2;
      if (impulse === 1'b1) got = 1'b1;
    end
    check("impulse_wait", {31'd0, got}, 32'd1);
    #5 nrst = 1'b0;
    #1;
    check("rst_pulse_impulse", {31'd0, impulse}, 32'd0);
    check("rst_pulse_level", {31'd0, btn_level}, 32'd0);
    @(negedge clk);
    release_reset();
    base = pulses_seen;
    hold(1'b1, 20);
    hold(1'b0, 15);
    check("rst_pulse_after_count", pulses_seen - base, 32'd1);

    // long hold: auto-repeat only when the feature is built in
    base = pulses_seen;
    hold(1'b1, 52);
    hold(1'b0, 15);
`ifdef BUTTON_REPEAT_EN
    n_expect_rep = 5;
`else
    n_expect_rep = 0;
`endif
    check("long_hold_count", pulses_seen - base, 1 + n_expect_rep);

    // randomized bouncing
    for (int k = 0; k < 60; k++) begin
      logic v;
      int   n;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) n = $urandom_range(6, 14);
      else n = $urandom_range(1, 5);
      hold(v, n);
    end
    hold(1'b0, 15);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
